// File: rtl/axi_lite_reg_master.sv
// axi_lite_reg_master
// Single-outstanding AXI4-Lite master. A command (write or read) is accepted
// on the CMD_* valid/ready port, executed as one AXI4-Lite transfer, and the
// result is presented on the RSP_* valid/ready port. A cycle counter aborts
// the transfer if the slave does not finish within C_TIMEOUT cycles.
//
// Ports:
//   M_AXI_ACLK, M_AXI_ARESET      clock, asynchronous active-high reset
//   CMD_VALID/READY/WRITE/ADDR/WDATA   command request port
//   RSP_VALID/READY/RDATA/RESP/TIMEOUT response port
//   BUSY                          high whenever the FSM is not IDLE
//   M_AXI_AW*/W*/B*/AR*/R*        AXI4-Lite master channels
module axi_lite_reg_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_TIMEOUT          = 16
) (
    input  logic                              M_AXI_ACLK,
    input  logic                              M_AXI_ARESET,
    input  logic                              CMD_VALID,
    output logic                              CMD_READY,
    input  logic                              CMD_WRITE,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     CMD_ADDR,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     CMD_WDATA,
    output logic                              RSP_VALID,
    input  logic                              RSP_READY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     RSP_RDATA,
    output logic [1:0]                        RSP_RESP,
    output logic                              RSP_TIMEOUT,
    output logic                              BUSY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic                              M_AXI_AWVALID,
    input  logic                              M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                              M_AXI_WVALID,
    input  logic                              M_AXI_WREADY,
    input  logic [1:0]                        M_AXI_BRESP,
    input  logic                              M_AXI_BVALID,
    output logic                              M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
    output logic                              M_AXI_ARVALID,
    input  logic                              M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
    input  logic [1:0]                        M_AXI_RRESP,
    input  logic                              M_AXI_RVALID,
    output logic                              M_AXI_RREADY
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR_REQ  = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_REQ  = 3'd3;
    localparam logic [2:0] S_RD_RESP = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    localparam int              TW   = $clog2(C_TIMEOUT + 1);
    localparam logic [TW-1:0]   TMAX = TW'(C_TIMEOUT);

    logic [2:0]                    state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                          aw_pend_q, aw_pend_d;
    logic                          w_pend_q, w_pend_d;
    logic [TW-1:0]                 timer_q, timer_d;
    logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                    resp_q, resp_d;
    logic                          to_q, to_d;
    logic                          abort;
    logic                          timeout_hit;

    assign timeout_hit = (timer_q == TMAX);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        timer_d   = timer_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        to_d      = to_q;
        abort     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    addr_d  = CMD_ADDR;
                    wdata_d = CMD_WDATA;
                    timer_d = '0;
                    if (CMD_WRITE) begin
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                        state_d   = S_WR_REQ;
                    end else begin
                        state_d   = S_RD_REQ;
                    end
                end
            end
            S_WR_REQ: begin
                timer_d   = timer_q + TW'(1);
                // Each channel retires independently on its own handshake.
                aw_pend_d = aw_pend_q & ~M_AXI_AWREADY;
                w_pend_d  = w_pend_q & ~M_AXI_WREADY;
                if (timeout_hit) begin
                    abort = 1'b1;
                end else if (!aw_pend_d && !w_pend_d) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                timer_d = timer_q + TW'(1);
                // A B beat on the timeout cycle wins over the abort.
                if (M_AXI_BVALID) begin
                    resp_d  = M_AXI_BRESP;
                    rdata_d = '0;
                    to_d    = 1'b0;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            S_RD_REQ: begin
                timer_d = timer_q + TW'(1);
                if (timeout_hit) begin
                    abort = 1'b1;
                end else if (M_AXI_ARREADY) begin
                    state_d = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                timer_d = timer_q + TW'(1);
                if (M_AXI_RVALID) begin
                    resp_d  = M_AXI_RRESP;
                    rdata_d = M_AXI_RDATA;
                    to_d    = 1'b0;
                    state_d = S_RESP;
                end else if (timeout_hit) begin
                    abort = 1'b1;
                end
            end
            S_RESP: begin
                if (RSP_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Hung-slave abort: drop every pending AXI request and report SLVERR.
        if (abort) begin
            aw_pend_d = 1'b0;
            w_pend_d  = 1'b0;
            resp_d    = 2'b10;
            rdata_d   = '0;
            to_d      = 1'b1;
            state_d   = S_RESP;
        end
    end

    always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
        if (M_AXI_ARESET) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            timer_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            to_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            timer_q   <= timer_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            to_q      <= to_d;
        end
    end

    // Every AXI output comes from registered state only.
    assign CMD_READY     = (state_q == S_IDLE);
    assign BUSY          = (state_q != S_IDLE);
    assign RSP_VALID     = (state_q == S_RESP);
    assign RSP_RDATA     = rdata_q;
    assign RSP_RESP      = resp_q;
    assign RSP_TIMEOUT   = to_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = aw_pend_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WVALID  = w_pend_q;
    assign M_AXI_BREADY  = (state_q == S_WR_RESP);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = (state_q == S_RD_REQ);
    assign M_AXI_RREADY  = (state_q == S_RD_RESP);

endmodule

// File: tb/tb_axi_lite_reg_master.sv
module tb_axi_lite_reg_master;

    localparam int NV = 1000;  // "never" for slave timing fields

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout, busy;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        bvalid, bready, arvalid, arready, rvalid, rready;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_lite_reg_master #(
        .C_M_AXI_ADDR_WIDTH(32),
        .C_M_AXI_DATA_WIDTH(32),
        .C_TIMEOUT(16)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .CMD_VALID    (cmd_valid),
        .CMD_READY    (cmd_ready),
        .CMD_WRITE    (cmd_write),
        .CMD_ADDR     (cmd_addr),
        .CMD_WDATA    (cmd_wdata),
        .RSP_VALID    (rsp_valid),
        .RSP_READY    (rsp_ready),
        .RSP_RDATA    (rsp_rdata),
        .RSP_RESP     (rsp_resp),
        .RSP_TIMEOUT  (rsp_timeout),
        .BUSY         (busy),
        .M_AXI_AWADDR (awaddr),
        .M_AXI_AWVALID(awvalid),
        .M_AXI_AWREADY(awready),
        .M_AXI_WDATA  (wdata),
        .M_AXI_WSTRB  (wstrb),
        .M_AXI_WVALID (wvalid),
        .M_AXI_WREADY (wready),
        .M_AXI_BRESP  (bresp),
        .M_AXI_BVALID (bvalid),
        .M_AXI_BREADY (bready),
        .M_AXI_ARADDR (araddr),
        .M_AXI_ARVALID(arvalid),
        .M_AXI_ARREADY(arready),
        .M_AXI_RDATA  (rdata),
        .M_AXI_RRESP  (rresp),
        .M_AXI_RVALID (rvalid),
        .M_AXI_RREADY (rready)
    );

    // Timing fields are the cycle index (1 = first cycle after the accepting
    // edge) from which the slave drives that READY/VALID. exp_lat counts clock
    // edges from acceptance until RSP_VALID is seen.
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic [31:0] rdat;
        int          aw_at, w_at, ar_at, b_at, r_at;
        logic [1:0]  bresp, rresp;
        int          hold;
        int          exp_lat;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic        exp_to;
        int          exp_aw, exp_w, exp_ar, exp_br;
    } vec_t;

    vec_t vecs[11];
    vec_t post_rst;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; rvalid = 1'b0;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge, idle again.
    task automatic run_vec(input int idx, input vec_t v);
        int c, lat, aw_n, w_n, ar_n, br_n, data_err, busy_err, waitc;
        bit b_done, r_done, got;
        aw_n = 0; w_n = 0; ar_n = 0; br_n = 0; data_err = 0; busy_err = 0;
        b_done = 0; r_done = 0; got = 0; lat = -1;
        bresp = v.bresp; rresp = v.rresp; rdata = v.rdat;
        cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdat;
        waitc = 0;
        while (!cmd_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        check("cmd_ready", {63'd0, cmd_ready}, 64'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (c = 1; c <= 40; c++) begin
            if (rsp_valid) begin
                lat = c - 1;
                got = 1;
                break;
            end
            if (!busy) busy_err++;
            awready = (c >= v.aw_at);
            wready  = (c >= v.w_at);
            arready = (c >= v.ar_at);
            bvalid  = (c >= v.b_at) && !b_done;
            rvalid  = (c >= v.r_at) && !r_done;
            #1;
            if (awvalid && awready) begin
                aw_n++;
                if (awaddr !== v.addr) data_err++;
            end
            if (wvalid && wready) begin
                w_n++;
                if (wdata !== v.wdat || wstrb !== 4'hF) data_err++;
            end
            if (arvalid && arready) begin
                ar_n++;
                if (araddr !== v.addr) data_err++;
            end
            if (bvalid && bready) begin br_n++; b_done = 1; end
            if (rvalid && rready) begin br_n++; r_done = 1; end
            @(negedge clk);
        end
        slave_idle();
        if (!got) begin
            n_cmp++; n_fail++;
            $display("FAIL vec%0d no_response: RSP_VALID absent after 40 cycles", idx);
            return;
        end
        $display("vec%0d %s addr=%h lat=%0d resp=%b rdata=%h to=%b beats aw/w/ar/br=%0d/%0d/%0d/%0d",
                 idx, v.write ? "WR" : "RD", v.addr, lat, rsp_resp, rsp_rdata, rsp_timeout,
                 aw_n, w_n, ar_n, br_n);
        check($sformatf("vec%0d latency", idx), 64'(lat), 64'(v.exp_lat));
        check($sformatf("vec%0d resp", idx), {62'd0, rsp_resp}, {62'd0, v.exp_resp});
        check($sformatf("vec%0d rdata", idx), {32'd0, rsp_rdata}, {32'd0, v.exp_rdata});
        check($sformatf("vec%0d timeout", idx), {63'd0, rsp_timeout}, {63'd0, v.exp_to});
        check($sformatf("vec%0d beats", idx),
              {16'(aw_n), 16'(w_n), 16'(ar_n), 16'(br_n)},
              {16'(v.exp_aw), 16'(v.exp_w), 16'(v.exp_ar), 16'(v.exp_br)});
        check($sformatf("vec%0d addr_data_errs", idx), 64'(data_err), 64'd0);
        check($sformatf("vec%0d busy_errs", idx), 64'(busy_err), 64'd0);
        check($sformatf("vec%0d axi_quiet", idx),
              {59'd0, awvalid, wvalid, bready, arvalid, rready}, 64'd0);
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check($sformatf("vec%0d hold%0d", idx, h),
                  {29'd0, rsp_valid, rsp_timeout, rsp_resp, rsp_rdata},
                  {29'd0, 1'b1, v.exp_to, v.exp_resp, v.exp_rdata});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check($sformatf("vec%0d back_idle", idx), {61'd0, cmd_ready, busy, rsp_valid}, 64'b100);
    endtask

    initial begin
        //           wr    addr          wdata         rdata         aw  w   ar  b   r   bresp  rresp  hold lat resp   exp_rdata     to  aw w ar br
        vecs[0]  = '{1'b1, 32'h75E00004, 32'hDEADBEEF, 32'hFFFFFFFF, 1,  1,  NV, 2,  NV, 2'b00, 2'b00, 0,   2,  2'b00, 32'h00000000, 0,  1, 1, 0, 1};
        vecs[1]  = '{1'b1, 32'h75E0000C, 32'h0000A5A5, 32'hFFFFFFFF, 1,  4,  NV, 5,  NV, 2'b00, 2'b00, 1,   5,  2'b00, 32'h00000000, 0,  1, 1, 0, 1};
        vecs[2]  = '{1'b1, 32'h75E00010, 32'h11112222, 32'hFFFFFFFF, 3,  1,  NV, 4,  NV, 2'b00, 2'b00, 0,   4,  2'b00, 32'h00000000, 0,  1, 1, 0, 1};
        vecs[3]  = '{1'b1, 32'h75E00014, 32'h33334444, 32'hFFFFFFFF, 2,  2,  NV, 3,  NV, 2'b01, 2'b00, 2,   3,  2'b01, 32'h00000000, 0,  1, 1, 0, 1};
        vecs[4]  = '{1'b0, 32'h75E00008, 32'h00000000, 32'h12345678, NV, NV, 1,  NV, 3,  2'b00, 2'b00, 5,   3,  2'b00, 32'h12345678, 0,  0, 0, 1, 1};
        vecs[5]  = '{1'b1, 32'h75E00018, 32'hCAFEF00D, 32'hFFFFFFFF, 1,  1,  NV, 2,  NV, 2'b10, 2'b00, 0,   2,  2'b10, 32'h00000000, 0,  1, 1, 0, 1};
        vecs[6]  = '{1'b0, 32'h75E0001C, 32'h00000000, 32'h0BADF00D, NV, NV, 2,  NV, 4,  2'b00, 2'b01, 0,   4,  2'b01, 32'h0BADF00D, 0,  0, 0, 1, 1};
        vecs[7]  = '{1'b0, 32'h75E00020, 32'h00000000, 32'h55AA55AA, NV, NV, 1,  NV, 17, 2'b00, 2'b00, 0,   17, 2'b00, 32'h55AA55AA, 0,  0, 0, 1, 1};
        vecs[8]  = '{1'b0, 32'h75E00024, 32'h00000000, 32'h77777777, NV, NV, 1,  NV, 18, 2'b00, 2'b00, 1,   17, 2'b10, 32'h00000000, 1,  0, 0, 1, 0};
        vecs[9]  = '{1'b1, 32'h75E00028, 32'h99999999, 32'hFFFFFFFF, NV, 1,  NV, NV, NV, 2'b00, 2'b00, 0,   17, 2'b10, 32'h00000000, 1,  0, 1, 0, 0};
        vecs[10] = '{1'b0, 32'h75E0002C, 32'h00000000, 32'h13579BDF, NV, NV, NV, NV, NV, 2'b00, 2'b00, 0,   17, 2'b10, 32'h00000000, 1,  0, 0, 0, 0};
        post_rst = '{1'b0, 32'h75E00030, 32'h00000000, 32'hA1B2C3D4, NV, NV, 1,  NV, 2,  2'b00, 2'b00, 0,   2,  2'b00, 32'hA1B2C3D4, 0,  0, 0, 1, 1};

        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; bresp = '0; rresp = '0; rdata = '0;
        slave_idle();
        #12;
        check("reset_state",
              {56'd0, cmd_ready, busy, rsp_valid, awvalid, wvalid, bready, arvalid, rready},
              {56'd0, 8'b1000_0000});
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_vec(i, vecs[i]);
        end

        // Late R beat while idle after the aborts must be ignored.
        rvalid = 1'b1; rdata = 32'hBAADBAAD;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("late_rvalid%0d", k), {61'd0, rready, rsp_valid, busy}, 64'd0);
        end
        rvalid = 1'b0;
        $display("late RVALID idle check done");

        // Asynchronous reset while waiting in WR_RESP.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h75E00040; cmd_wdata = 32'h0F0F0F0F;
        @(negedge clk);
        cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        check("pre_reset_bready", {62'd0, bready, busy}, 64'b11);
        #2 rst = 1'b1;
        #1;
        check("async_reset", {60'd0, bready, busy, rsp_valid, cmd_ready}, 64'b0001);
        $display("reset mid WR_RESP: bready=%b busy=%b rsp_valid=%b", bready, busy, rsp_valid);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", {62'd0, cmd_ready, busy}, 64'b10);
        run_vec(11, post_rst);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_reg_master.md
Name: axi_lite_reg_master

Overview:
- Single-outstanding AXI4-Lite master that issues 32-bit register writes and reads to the noise-cancelling peripheral's AXI4-Lite slave register bank, for example to program filter coefficients into registers A..J.
- Driven by a simple valid/ready command port; each result returns on a valid/ready response port.
- A bounded timeout guarantees progress if the slave never responds.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32: address width of the command port and the AW/AR channels.
- C_M_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_TIMEOUT, 16: cycles allowed from command acceptance to B/R handshake before abort; minimum 2.

Ports:
- M_AXI_ACLK  in  1  sole clock.
- M_AXI_ARESET  in  1  reset, asynchronous, active-high.
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted when high together with CMD_VALID.
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  32  byte address.
- CMD_WDATA  in  32  write data.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumed.
- RSP_RDATA  out  32  read data; 0 for writes.
- RSP_RESP  out  2  AXI response code, or 2'b10 on timeout.
- RSP_TIMEOUT  out  1  transaction aborted by timeout.
- BUSY  out  1  high in any state other than IDLE.
- M_AXI_AWADDR out 32, M_AXI_AWVALID out 1, M_AXI_AWREADY in 1: write address channel.
- M_AXI_WDATA out 32, M_AXI_WSTRB out 4, M_AXI_WVALID out 1, M_AXI_WREADY in 1: write data channel.
- M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1: write response channel.
- M_AXI_ARADDR out 32, M_AXI_ARVALID out 1, M_AXI_ARREADY in 1: read address channel.
- M_AXI_RDATA in 32, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1: read data channel.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. Reset forces the FSM to IDLE and clears all VALID/READY outputs, RSP_* outputs, BUSY and the timeout counter immediately, mid-transaction included.
- IDLE: CMD_READY = 1. On CMD_VALID:
  - Register CMD_ADDR, CMD_WDATA and CMD_WRITE; clear the timer.
  - Next state is WR_REQ if CMD_WRITE = 1, otherwise RD_REQ.
- WR_REQ:
  - AWVALID and WVALID assert together in the first cycle after acceptance.
  - Each channel drops independently on the cycle after its own READY handshake; AW-before-W, W-before-AW and simultaneous handshakes are all legal.
  - Once both channels have handshaken, go to WR_RESP.
- WR_RESP: BREADY = 1. On BVALID, capture BRESP and go to RESP.
- RD_REQ: ARVALID = 1 until the ARREADY handshake, then go to RD_RESP.
- RD_RESP: RREADY = 1. On RVALID, capture RDATA and RRESP and go to RESP.
- RESP:
  - RSP_VALID = 1; outputs stay stable until RSP_READY.
  - On handshake go to IDLE; CMD_READY reasserts the following cycle.
  - Back-to-back throughput is therefore at best one command per 4 cycles.
- Timeout:
  - The counter increments every cycle in WR_REQ, WR_RESP, RD_REQ and RD_RESP.
  - When it reaches C_TIMEOUT with no completing handshake, all AXI valid/ready outputs drop next cycle and the FSM enters RESP with RSP_TIMEOUT = 1, RSP_RESP = 2'b10 and RSP_RDATA = 0.
  - A B/R handshake in the same cycle as the timeout takes priority: a normal response is returned.
  - Abort deliberately violates AXI valid-stability; it exists only for debug of a hung slave.
  - Late B or R beats after an abort are ignored, because BREADY and RREADY are held at 0.
- Fixed and don't-care values:
  - WSTRB = 4'hF always.
  - RSP_RDATA = 0 for writes.
  - AW/AR addresses are driven from the registered address and are held stable while VALID is high.
- No combinational path from any AXI input to any AXI output.

Test Plan:
- Write 0x75E00004 ← 0xDEADBEEF with AWREADY = WREADY = 1 immediately and BVALID after 1 cycle, BRESP = 00 → one AW and one W beat, WSTRB = F, RSP_VALID with RSP_RESP = 00 and RSP_TIMEOUT = 0.
- Write where WREADY arrives 3 cycles after AWREADY → AWVALID drops after its own handshake, WVALID holds until its handshake, exactly one beat per channel.
- Read 0x75E00008 with RVALID after 2 cycles, RDATA = 0x12345678, RRESP = 00 → RSP_RDATA = 0x12345678; RSP_READY held low for 5 cycles → response held stable throughout.
- Read with the slave never asserting RVALID, C_TIMEOUT = 16 → RSP_TIMEOUT = 1 and RSP_RESP = 10 at cycle 17 after acceptance; RREADY = 0 afterwards, and a later RVALID is ignored.
- Assert reset during WR_RESP → BREADY, BUSY and RSP_VALID go 0 without waiting for a clock edge; after release, CMD_READY = 1 and a new read completes normally.
- Slave returns BRESP = 10 (SLVERR) → RSP_RESP = 10 with RSP_TIMEOUT = 0.
